// File: rtl/soc_top.sv
// soc_top: single-cycle RV32I-subset core plus word-addressed instruction/data RAMs.
// Latency: one instruction retires per clk edge; no backpressure, memories answer combinationally.
// Optional feature macro SOC_TRACE_EN: per-edge retirement trace printed by the core.

module soc_top #(
    parameter int          IMEM_DEPTH = 256,
    parameter int          DMEM_DEPTH = 256,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input logic clk,
    input logic rst
);
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_we;

    soc_core #(.RESET_PC(RESET_PC)) core_inst (
        .clk        (clk),
        .rst        (rst),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_we    (dmem_we),
        .dmem_rdata (dmem_rdata)
    );

    soc_mem_controller #(.IMEM_DEPTH(IMEM_DEPTH), .DMEM_DEPTH(DMEM_DEPTH)) mem_controller_inst (
        .clk        (clk),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_we    (dmem_we),
        .dmem_rdata (dmem_rdata)
    );
endmodule

// Word RAM: combinational read, synchronous write; byte address wraps modulo DEPTH.
module soc_ram #(
    parameter int DEPTH = 256
) (
    input  logic        clk,
    input  logic [31:0] addr,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic [31:0] rdata
);
    localparam int AW = $clog2(DEPTH);

    logic [31:0]   mem [0:DEPTH-1];
    logic [AW-1:0] idx;
    logic          unused_addr_bits;

    assign idx              = addr[AW+1:2];
    assign unused_addr_bits = ^{addr[31:AW+2], addr[1:0]};
    assign rdata            = mem[idx];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
    end
endmodule

module soc_mem_controller #(
    parameter int IMEM_DEPTH = 256,
    parameter int DMEM_DEPTH = 256
) (
    input  logic        clk,
    input  logic [31:0] imem_addr,
    output logic [31:0] imem_rdata,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_wdata,
    input  logic        dmem_we,
    output logic [31:0] dmem_rdata
);
    // Instruction RAM is only ever loaded from outside the design.
    soc_ram #(.DEPTH(IMEM_DEPTH)) instr_ram (
        .clk   (clk),
        .addr  (imem_addr),
        .we    (1'b0),
        .wdata ('0),
        .rdata (imem_rdata)
    );

    soc_ram #(.DEPTH(DMEM_DEPTH)) data_ram (
        .clk   (clk),
        .addr  (dmem_addr),
        .we    (dmem_we),
        .wdata (dmem_wdata),
        .rdata (dmem_rdata)
    );
endmodule

module soc_regfile (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  raddr1,
    output logic [31:0] rdata1,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata2,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata
);
    logic [31:0] regs [0:31];

    assign rdata1 = (raddr1 == 5'd0) ? 32'd0 : regs[raddr1];
    assign rdata2 = (raddr2 == 5'd0) ? 32'd0 : regs[raddr2];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= 32'd0;
            end
        end else if (we && waddr != 5'd0) begin
            regs[waddr] <= wdata;
        end
    end
endmodule

module soc_core #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic        dmem_we,
    input  logic [31:0] dmem_rdata
);
    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_AUIPC  = 7'h17;
    localparam logic [6:0] OPC_JAL    = 7'h6F;
    localparam logic [6:0] OPC_JALR   = 7'h67;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_IMM    = 7'h13;
    localparam logic [6:0] OPC_OP     = 7'h33;

    logic [31:0] pc;
    logic [31:0] pc_d;
    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] rs1_val, rs2_val, pc_plus4;
    logic [31:0] alu_b, alu_res, rd_wdata;
    logic [4:0]  shamt;
    logic        alu_ok, rd_we, st_en;

    assign instr     = imem_rdata;
    assign imem_addr = pc;
    assign opcode    = instr[6:0];
    assign rd        = instr[11:7];
    assign funct3    = instr[14:12];
    assign rs1       = instr[19:15];
    assign rs2       = instr[24:20];
    assign imm_i     = {{20{instr[31]}}, instr[31:20]};
    assign imm_s     = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b     = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u     = {instr[31:12], 12'd0};
    assign imm_j     = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    assign pc_plus4  = pc + 32'd4;

    soc_regfile rf (
        .clk    (clk),
        .rst    (rst),
        .raddr1 (rs1),
        .rdata1 (rs1_val),
        .raddr2 (rs2),
        .rdata2 (rs2_val),
        .we     (rd_we),
        .waddr  (rd),
        .wdata  (rd_wdata)
    );

    assign dmem_addr  = rs1_val + ((opcode == OPC_STORE) ? imm_s : imm_i);
    assign dmem_wdata = rs2_val;
    assign dmem_we    = st_en & ~rst;

    // Shared ALU for OP and OP-IMM; SLTIU is outside the subset and reports !alu_ok.
    assign alu_b = (opcode == OPC_OP) ? rs2_val : imm_i;
    assign shamt = alu_b[4:0];

    always_comb begin
        alu_res = 32'd0;
        alu_ok  = 1'b1;
        case (funct3)
            3'b000:  alu_res = (opcode == OPC_OP && instr[30]) ? rs1_val - alu_b : rs1_val + alu_b;
            3'b001:  alu_res = rs1_val << shamt;
            3'b010:  alu_res = {31'd0, $signed(rs1_val) < $signed(alu_b)};
            3'b011: begin
                alu_res = {31'd0, rs1_val < alu_b};
                alu_ok  = (opcode == OPC_OP);
            end
            3'b100:  alu_res = rs1_val ^ alu_b;
            3'b101:  alu_res = instr[30] ? 32'($signed(rs1_val) >>> shamt) : rs1_val >> shamt;
            3'b110:  alu_res = rs1_val | alu_b;
            default: alu_res = rs1_val & alu_b;
        endcase
    end

    always_comb begin
        pc_d     = pc_plus4;
        rd_we    = 1'b0;
        rd_wdata = 32'd0;
        st_en    = 1'b0;
        case (opcode)
            OPC_LUI: begin
                rd_we    = 1'b1;
                rd_wdata = imm_u;
            end
            OPC_AUIPC: begin
                rd_we    = 1'b1;
                rd_wdata = pc + imm_u;
            end
            OPC_IMM, OPC_OP: begin
                rd_we    = alu_ok;
                rd_wdata = alu_res;
            end
            OPC_LOAD: begin
                rd_we    = (funct3 == 3'b010);
                rd_wdata = dmem_rdata;
            end
            OPC_STORE: st_en = (funct3 == 3'b010);
            OPC_BRANCH: begin
                if ((funct3 == 3'b000 && rs1_val == rs2_val) ||
                    (funct3 == 3'b001 && rs1_val != rs2_val)) begin
                    pc_d = pc + imm_b;
                end
            end
            OPC_JAL: begin
                rd_we    = 1'b1;
                rd_wdata = pc_plus4;
                pc_d     = pc + imm_j;
            end
            OPC_JALR: begin
                rd_we    = (funct3 == 3'b000);
                rd_wdata = pc_plus4;
                pc_d     = (funct3 == 3'b000) ? ((rs1_val + imm_i) & ~32'd1) : pc_plus4;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_d;
        end
    end

`ifdef SOC_TRACE_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (dmem_we) begin
                $display("TRACE pc=%h instr=%h rd=%h wd=-- st=%h/%h", pc, instr, rd, dmem_addr, dmem_wdata);
            end else if (rd_we && rd != 5'd0) begin
                $display("TRACE pc=%h instr=%h rd=%h wd=%h", pc, instr, rd, rd_wdata);
            end else begin
                $display("TRACE pc=%h instr=%h rd=%h wd=--", pc, instr, rd);
            end
        end
    end
`endif
endmodule

// File: tb/tb_soc_top.sv
// Bench for soc_top: directed programs from abstract instruction records plus random
// straight-line programs checked against an instruction-level reference model.
module tb_soc_top;
    logic clk = 1'b0;
    logic rst = 1'b1;

    soc_top dut (
        .clk (clk),
        .rst (rst)
    );

    always #5 clk = ~clk;

    typedef enum logic [4:0] {
        I_NOPW, I_LUI, I_AUIPC, I_ADDI, I_SLTI, I_XORI, I_ORI, I_ANDI, I_SLLI, I_SRLI,
        I_SRAI, I_ADD, I_SUB, I_SLT, I_SLTU, I_XOR, I_OR, I_AND, I_SLL, I_SRL,
        I_SRA, I_LW, I_SW, I_BEQ, I_BNE, I_JAL, I_JALR
    } op_e;

    typedef struct packed {
        op_e         op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } ins_t;

    ins_t        prog   [0:255];
    logic [31:0] m_regs [0:31];
    logic [31:0] m_dmem [0:255];
    logic [31:0] m_pc;
    int          checks = 0;
    int          errors = 0;

    function automatic ins_t mk(op_e op, int rd, int rs1, int rs2, logic [31:0] imm);
        ins_t t;
        t.op  = op;
        t.rd  = 5'(rd);
        t.rs1 = 5'(rs1);
        t.rs2 = 5'(rs2);
        t.imm = imm;
        return t;
    endfunction

    // Machine encoding straight from the RV32I instruction formats.
    function automatic logic [31:0] enc(ins_t t);
        logic [31:0] m;
        m = t.imm;
        case (t.op)
            I_LUI:   return {m[31:12], t.rd, 7'h37};
            I_AUIPC: return {m[31:12], t.rd, 7'h17};
            I_ADDI:  return {m[11:0], t.rs1, 3'b000, t.rd, 7'h13};
            I_SLTI:  return {m[11:0], t.rs1, 3'b010, t.rd, 7'h13};
            I_XORI:  return {m[11:0], t.rs1, 3'b100, t.rd, 7'h13};
            I_ORI:   return {m[11:0], t.rs1, 3'b110, t.rd, 7'h13};
            I_ANDI:  return {m[11:0], t.rs1, 3'b111, t.rd, 7'h13};
            I_SLLI:  return {7'h00, m[4:0], t.rs1, 3'b001, t.rd, 7'h13};
            I_SRLI:  return {7'h00, m[4:0], t.rs1, 3'b101, t.rd, 7'h13};
            I_SRAI:  return {7'h20, m[4:0], t.rs1, 3'b101, t.rd, 7'h13};
            I_ADD:   return {7'h00, t.rs2, t.rs1, 3'b000, t.rd, 7'h33};
            I_SUB:   return {7'h20, t.rs2, t.rs1, 3'b000, t.rd, 7'h33};
            I_SLL:   return {7'h00, t.rs2, t.rs1, 3'b001, t.rd, 7'h33};
            I_SLT:   return {7'h00, t.rs2, t.rs1, 3'b010, t.rd, 7'h33};
            I_SLTU:  return {7'h00, t.rs2, t.rs1, 3'b011, t.rd, 7'h33};
            I_XOR:   return {7'h00, t.rs2, t.rs1, 3'b100, t.rd, 7'h33};
            I_SRL:   return {7'h00, t.rs2, t.rs1, 3'b101, t.rd, 7'h33};
            I_SRA:   return {7'h20, t.rs2, t.rs1, 3'b101, t.rd, 7'h33};
            I_OR:    return {7'h00, t.rs2, t.rs1, 3'b110, t.rd, 7'h33};
            I_AND:   return {7'h00, t.rs2, t.rs1, 3'b111, t.rd, 7'h33};
            I_LW:    return {m[11:0], t.rs1, 3'b010, t.rd, 7'h03};
            I_SW:    return {m[11:5], t.rs2, t.rs1, 3'b010, m[4:0], 7'h23};
            I_BEQ:   return {m[12], m[10:5], t.rs2, t.rs1, 3'b000, m[4:1], m[11], 7'h63};
            I_BNE:   return {m[12], m[10:5], t.rs2, t.rs1, 3'b001, m[4:1], m[11], 7'h63};
            I_JAL:   return {m[20], m[10:1], m[11], m[19:12], t.rd, 7'h6F};
            I_JALR:  return {m[11:0], t.rs1, 3'b000, t.rd, 7'h67};
            default: return 32'h0000_0000;
        endcase
    endfunction

    function automatic ins_t rand_ins();
        ins_t        t;
        logic [31:0] v;
        v     = $urandom();
        t.op  = op_e'(5'($urandom_range(0, 24)));
        t.rd  = 5'($urandom_range(0, 31));
        t.rs1 = 5'($urandom_range(0, 31));
        t.rs2 = 5'($urandom_range(0, 31));
        case (t.op)
            I_LUI, I_AUIPC:   t.imm = {v[31:12], 12'd0};
            I_SLLI, I_SRLI, I_SRAI: t.imm = {27'd0, v[4:0]};
            I_BEQ, I_BNE:     t.imm = 32'd8;
            I_LW, I_SW: begin
                // word 0..15, optionally aliased one DMEM_DEPTH higher, with junk low bits
                t.rs1 = 5'd0;
                t.imm = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 1) * 1024 + $urandom_range(0, 3));
            end
            default:          t.imm = {{20{v[11]}}, v[11:0]};
        endcase
        return t;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 256; i++) prog[i] = mk(I_NOPW, 0, 0, 0, 32'd0);
    endtask

    task automatic load_prog();
        rst = 1'b1;
        for (int i = 0; i < 256; i++) dut.mem_controller_inst.instr_ram.mem[i] = enc(prog[i]);
        @(negedge clk);
        @(negedge clk);
        rst  = 1'b0;
        m_pc = 32'd0;
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    endtask

    task automatic model_step();
        ins_t        t;
        logic [31:0] a, b, wv, npc;
        bit          we;
        t   = prog[(m_pc >> 2) & 32'd255];
        a   = m_regs[t.rs1];
        b   = m_regs[t.rs2];
        npc = m_pc + 32'd4;
        wv  = 32'd0;
        we  = 1'b1;
        case (t.op)
            I_LUI:   wv = t.imm;
            I_AUIPC: wv = m_pc + t.imm;
            I_ADDI:  wv = a + t.imm;
            I_SLTI:  wv = ($signed(a) < $signed(t.imm)) ? 32'd1 : 32'd0;
            I_XORI:  wv = a ^ t.imm;
            I_ORI:   wv = a | t.imm;
            I_ANDI:  wv = a & t.imm;
            I_SLLI:  wv = a << t.imm[4:0];
            I_SRLI:  wv = a >> t.imm[4:0];
            I_SRAI:  wv = $signed(a) >>> t.imm[4:0];
            I_ADD:   wv = a + b;
            I_SUB:   wv = a - b;
            I_SLT:   wv = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            I_SLTU:  wv = (a < b) ? 32'd1 : 32'd0;
            I_XOR:   wv = a ^ b;
            I_OR:    wv = a | b;
            I_AND:   wv = a & b;
            I_SLL:   wv = a << b[4:0];
            I_SRL:   wv = a >> b[4:0];
            I_SRA:   wv = $signed(a) >>> b[4:0];
            I_LW:    wv = m_dmem[((a + t.imm) >> 2) & 32'd255];
            I_SW: begin
                we = 1'b0;
                m_dmem[((a + t.imm) >> 2) & 32'd255] = b;
            end
            I_BEQ: begin
                we = 1'b0;
                if (a == b) npc = m_pc + t.imm;
            end
            I_BNE: begin
                we = 1'b0;
                if (a != b) npc = m_pc + t.imm;
            end
            I_JAL: begin
                wv  = m_pc + 32'd4;
                npc = m_pc + t.imm;
            end
            I_JALR: begin
                wv  = m_pc + 32'd4;
                npc = (a + t.imm) & ~32'd1;
            end
            default: we = 1'b0;
        endcase
        if (we && t.rd != 5'd0) m_regs[t.rd] = wv;
        m_pc = npc;
    endtask

    task automatic check_loop(input string tag);
        for (int k = 0; k <= 9; k++) begin
            if (k > 0) @(negedge clk);
            check({tag, "_pc"}, dut.core_inst.pc, (k == 0) ? 32'd0 : (k == 1) ? 32'd4 : (k % 2 == 0) ? 32'd8 : 32'd12);
            check({tag, "_x1"}, dut.core_inst.rf.regs[1], (k >= 3) ? 32'((k - 1) / 2) : 32'd0);
        end
    endtask

    initial begin
        // power-on reset
        clear_prog();
        for (int i = 0; i < 256; i++) dut.mem_controller_inst.instr_ram.mem[i] = 32'd0;
        repeat (2) @(negedge clk);
        check("por_pc", dut.core_inst.pc, 32'd0);
        for (int i = 0; i < 32; i++) check("por_reg", dut.core_inst.rf.regs[i], 32'd0);

        // BEQ taken / not taken
        clear_prog();
        prog[0] = mk(I_ADDI, 1, 0, 0, 32'd5);
        prog[1] = mk(I_ADDI, 2, 0, 0, 32'd5);
        prog[2] = mk(I_BEQ, 0, 1, 2, 32'd8);
        prog[3] = mk(I_ADDI, 3, 0, 0, 32'd1);
        prog[4] = mk(I_ADDI, 4, 0, 0, 32'd2);
        prog[5] = mk(I_BEQ, 0, 1, 0, 32'd8);
        prog[6] = mk(I_ADDI, 5, 0, 0, 32'd3);
        prog[7] = mk(I_JAL, 0, 0, 0, 32'd0);
        load_prog();
        check("beq_pc0", dut.core_inst.pc, 32'd0);
        @(negedge clk); check("beq_pc1", dut.core_inst.pc, 32'd4);
        @(negedge clk); check("beq_pc2", dut.core_inst.pc, 32'd8);
        @(negedge clk); check("beq_pc3", dut.core_inst.pc, 32'd16);
        @(negedge clk); check("beq_pc4", dut.core_inst.pc, 32'd20);
        @(negedge clk); check("beq_pc5", dut.core_inst.pc, 32'd24);
        repeat (5) @(negedge clk);
        check("beq_x3", dut.core_inst.rf.regs[3], 32'd0);
        check("beq_x4", dut.core_inst.rf.regs[4], 32'd2);
        check("beq_x5", dut.core_inst.rf.regs[5], 32'd3);
        check("beq_pc_end", dut.core_inst.pc, 32'd28);

        // store then immediate load, then reset with register history
        clear_prog();
        prog[0] = mk(I_ADDI, 1, 0, 0, 32'h7F);
        prog[1] = mk(I_SW, 0, 0, 1, 32'd8);
        prog[2] = mk(I_LW, 2, 0, 0, 32'd8);
        prog[3] = mk(I_JAL, 0, 0, 0, 32'd0);
        load_prog();
        @(negedge clk); check("ls_x1", dut.core_inst.rf.regs[1], 32'h7F);
        @(negedge clk); check("ls_mem2", dut.mem_controller_inst.data_ram.mem[2], 32'h7F);
        @(negedge clk); check("ls_x2", dut.core_inst.rf.regs[2], 32'h7F);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_pc", dut.core_inst.pc, 32'd0);
        for (int i = 1; i < 32; i++) check("rst_reg", dut.core_inst.rf.regs[i], 32'd0);
        check("rst_mem2", dut.mem_controller_inst.data_ram.mem[2], 32'h7F);
        rst = 1'b0;

        // x0 and ALU corner values
        clear_prog();
        prog[0] = mk(I_ADDI, 0, 0, 0, 32'd9);
        prog[1] = mk(I_LUI, 6, 0, 0, 32'h8000_0000);
        prog[2] = mk(I_SRAI, 7, 6, 0, 32'd4);
        prog[3] = mk(I_ADDI, 1, 0, 0, 32'd1);
        prog[4] = mk(I_SUB, 8, 0, 1, 32'd0);
        prog[5] = mk(I_SLT, 9, 8, 0, 32'd0);
        prog[6] = mk(I_JAL, 0, 0, 0, 32'd0);
        load_prog();
        repeat (8) @(negedge clk);
        check("alu_x0", dut.core_inst.rf.regs[0], 32'd0);
        check("alu_x6", dut.core_inst.rf.regs[6], 32'h8000_0000);
        check("alu_x7", dut.core_inst.rf.regs[7], 32'hF800_0000);
        check("alu_x8", dut.core_inst.rf.regs[8], 32'hFFFF_FFFF);
        check("alu_x9", dut.core_inst.rf.regs[9], 32'd1);
        check("alu_pc", dut.core_inst.pc, 32'd24);

        // JAL / JALR
        clear_prog();
        prog[0] = mk(I_JAL, 1, 0, 0, 32'd12);
        prog[1] = mk(I_ADDI, 10, 0, 0, 32'h55);
        prog[2] = mk(I_JAL, 0, 0, 0, 32'd0);
        prog[3] = mk(I_JALR, 0, 1, 0, 32'd0);
        load_prog();
        @(negedge clk);
        check("jal_pc", dut.core_inst.pc, 32'd12);
        check("jal_x1", dut.core_inst.rf.regs[1], 32'd4);
        @(negedge clk); check("jalr_pc", dut.core_inst.pc, 32'd4);
        @(negedge clk);
        check("jalr_next_pc", dut.core_inst.pc, 32'd8);
        check("jalr_x10", dut.core_inst.rf.regs[10], 32'h55);

        // all-zero word as NOP, loop, mid-run reset, identical rerun
        clear_prog();
        prog[0] = mk(I_ADDI, 1, 0, 0, 32'd0);
        prog[1] = mk(I_NOPW, 0, 0, 0, 32'd0);
        prog[2] = mk(I_ADDI, 1, 1, 0, 32'd1);
        prog[3] = mk(I_JAL, 0, 0, 0, 32'hFFFF_FFFC);
        load_prog();
        check_loop("loop");
        rst = 1'b1;
        @(negedge clk);
        check("midrst_pc", dut.core_inst.pc, 32'd0);
        check("midrst_x1", dut.core_inst.rf.regs[1], 32'd0);
        rst = 1'b0;
        check_loop("rerun");

        // random straight-line programs against the reference model
        for (int it = 0; it < 3; it++) begin
            int n;
            n = 0;
            clear_prog();
            for (int k = 0; k < 16; k++) begin
                prog[n] = mk(I_SW, 0, 0, 0, 32'(k * 4));
                n++;
            end
            for (int k = 0; k < 60; k++) begin
                prog[n] = rand_ins();
                n++;
            end
            prog[n]     = mk(I_JAL, 0, 0, 0, 32'd0);
            prog[n + 1] = mk(I_JAL, 0, 0, 0, 32'd0);
            load_prog();
            for (int c = 0; c < n + 4; c++) begin
                check("rnd_pc", dut.core_inst.pc, m_pc);
                model_step();
                @(negedge clk);
            end
            check("rnd_pc_end", dut.core_inst.pc, m_pc);
            for (int i = 1; i < 32; i++) check("rnd_reg", dut.core_inst.rf.regs[i], m_regs[i]);
            for (int i = 0; i < 16; i++) check("rnd_dmem", dut.mem_controller_inst.data_ram.mem[i], m_dmem[i]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/soc_top.md
Name: soc_top

Overview:
- Minimal single-cycle RV32I-subset SoC: one core, a memory controller wrapping a word-addressed instruction RAM and data RAM.
- No external I/O besides clock and reset. Programs and data are preloaded by the bench with $readmemh.
- Required hierarchy, fixed so benches can load memories and probe state:
  - soc_top.mem_controller_inst.instr_ram.mem
  - soc_top.mem_controller_inst.data_ram.mem
  - soc_top.core_inst.rf.regs
  - soc_top.core_inst.pc

Parameters:
- IMEM_DEPTH, 256, instruction RAM depth in 32-bit words (power of 2).
- DMEM_DEPTH, 256, data RAM depth in 32-bit words (power of 2).
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset; one clock, synchronous and active-high.

Behaviour:
- Memories:
  - Each RAM is declared as mem[0:DEPTH-1] of 32 bits, one hex word per file line.
  - Contents are not touched by reset.
  - Reads are combinational; data RAM writes are synchronous.
  - Word index is addr[log2(DEPTH)+1:2]. Out-of-range addresses wrap modulo DEPTH. Low two address bits are ignored; no misalignment trap.
- Register file:
  - 32x32; reads combinational, write on clock edge.
  - x0 reads 0 always; writes to x0 are discarded.
  - All registers clear to 0 on reset.
- Reset:
  - While rst=1 at an edge: pc<=RESET_PC, registers cleared, no memory write, no register write.
  - Reset asserted mid-program aborts the current instruction; execution restarts at RESET_PC on the first edge with rst=0.
- Execution:
  - One instruction retires per clock.
  - Instruction fetched from instr_ram at pc; decoded, executed and written back in the same cycle.
  - Register/PC/store updates occur on the next rising edge.
- Supported instructions:
  - LUI, AUIPC
  - ADDI, SLTI, XORI, ORI, ANDI, SLLI, SRLI, SRAI
  - ADD, SUB, SLT, SLTU, XOR, OR, AND, SLL, SRL, SRA
  - LW, SW
  - BEQ, BNE
  - JAL, JALR
- Arithmetic and width rules:
  - Arithmetic is 32-bit, wrap-around, no overflow flags.
  - Immediates are sign-extended per the RV32I encoding.
  - Shift amount is the low 5 bits.
  - SLT is signed; SLTU is unsigned.
- Next PC:
  - Default pc+4.
  - Taken branch: pc+imm_b.
  - JAL: pc+imm_j, with rd<=pc+4.
  - JALR: (rs1+imm_i)&~1, with rd<=pc+4.
  - Branch compare uses full 32-bit equality.
- Load/store:
  - LW writes rd with data_ram[rs1+imm_i].
  - SW writes rs2 to data_ram[rs1+imm_s] on the edge.
  - A store followed by a load to the same address in the next cycle returns the new data.
- Any other opcode (including all-zero or X words) executes as a NOP: pc+4, no register or memory write.
- PC wraps naturally at 32 bits; fetch wraps modulo IMEM_DEPTH.

Optional Feature:
- Macro SOC_TRACE_EN.
- Defined: on every rising edge with rst=0, the core prints one $display line with the following, each in hex:
  - pc
  - instruction
  - rd index
  - rd write value (or "--" if no write)
  - store address/data (if SW)
- Undefined: no trace logic or system tasks are compiled; functional behaviour is identical.

Test Plan:
- Reset: hold rst=1 for 2 edges with arbitrary register history -> pc=0, all regs[1..31]=0, data_ram unchanged.
- BEQ taken/not-taken, program: addi x1,x0,5; addi x2,x0,5; beq x1,x2,+8; addi x3,x0,1; addi x4,x0,2; beq x1,x0,+8; addi x5,x0,3.
  - Expect after ~10 cycles: x3=0, x4=2, x5=3.
  - pc sequence 0,4,8,16,20,24.
- Load/store: addi x1,x0,0x7F; sw x1,8(x0); lw x2,8(x0) -> data_ram.mem[2]=0x7F, x2=0x7F the cycle after lw retires.
- x0 and ALU:
  - addi x0,x0,9 -> x0 reads 0.
  - lui x6,0x80000; srai x7,x6,4 -> x7=0xF800_0000.
  - sub x8,x0,x1 with x1=1 -> x8=0xFFFF_FFFF, slt x9,x8,x0 -> x9=1.
- Jumps: jal x1,+12 at pc=0 -> x1=4, next pc=12; jalr x0,0(x1) -> pc=4.
- Mid-run reset and illegal opcode:
  - Assert rst for one edge during a loop -> pc=0 next cycle, regs 0, then the program reruns identically.
  - An all-zero word acts as a NOP (pc+4).
